// File: rtl/id_ex_pipe.sv
// ============================================================================
// Module      : id_ex_pipe
// Description : ID/EX pipeline register with EX/MEM and MEM/WB operand
//               forwarding, ALUSrc select and load-use hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipe #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk__i,
  input  logic          rstn__i,
  input  logic          stall__i,
  input  logic          flush__i,
  input  logic          valid__i,
  input  logic [DW-1:0] rsData__i,
  input  logic [DW-1:0] rtData__i,
  input  logic [DW-1:0] imm__i,
  input  logic [RW-1:0] rs__i,
  input  logic [RW-1:0] rt__i,
  input  logic [RW-1:0] rd__i,
  input  logic [2:0]    ALUCtrl__i,
  input  logic          ALUSrc__i,
  input  logic          RegDst__i,
  input  logic          RegWrite__i,
  input  logic          MemRead__i,
  input  logic          MemWrite__i,
  input  logic          MemToReg__i,
  input  logic          Branch__i,
  input  logic          exmemRegWrite__i,
  input  logic [RW-1:0] exmemRd__i,
  input  logic [DW-1:0] exmemResult__i,
  input  logic          memwbRegWrite__i,
  input  logic [RW-1:0] memwbRd__i,
  input  logic [DW-1:0] memwbData__i,
  output logic [DW-1:0] dataA__o,
  output logic [DW-1:0] dataB__o,
  output logic [2:0]    ALUCtrl__o,
  output logic [DW-1:0] storeData__o,
  output logic [RW-1:0] writeReg__o,
  output logic          valid__o,
  output logic          RegWrite__o,
  output logic          MemRead__o,
  output logic          MemWrite__o,
  output logic          MemToReg__o,
  output logic          Branch__o,
  output logic          loadUseHazard__o
);

  logic          r_valid;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_write_reg;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [DW-1:0] r_imm;
  logic [2:0]    r_alu_ctrl;
  logic          r_alu_src;
  logic          r_reg_write;
  logic          r_mem_read;
  logic          r_mem_write;
  logic          r_mem_to_reg;
  logic          r_branch;

  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_b;

  always_ff @(posedge clk__i or negedge rstn__i) begin
    if (!rstn__i || flush__i) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_write_reg  <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_alu_ctrl   <= '0;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else if (!stall__i) begin
      r_valid      <= valid__i;
      r_rs         <= rs__i;
      r_rt         <= rt__i;
      r_write_reg  <= RegDst__i ? rd__i : rt__i;
      r_rs_data    <= rsData__i;
      r_rt_data    <= rtData__i;
      r_imm        <= imm__i;
      r_alu_ctrl   <= ALUCtrl__i;
      r_alu_src    <= ALUSrc__i;
      r_reg_write  <= RegWrite__i;
      r_mem_read   <= MemRead__i;
      r_mem_write  <= MemWrite__i;
      r_mem_to_reg <= MemToReg__i;
      r_branch     <= Branch__i;
    end
  end

  // The younger EX/MEM result wins; register 0 is hardwired and never forwarded.
  always_comb begin
    w_fwd_a = r_rs_data;
    if (exmemRegWrite__i && (exmemRd__i != '0) && (exmemRd__i == r_rs))
      w_fwd_a = exmemResult__i;
    else if (memwbRegWrite__i && (memwbRd__i != '0) && (memwbRd__i == r_rs))
      w_fwd_a = memwbData__i;
  end

  always_comb begin
    w_fwd_b = r_rt_data;
    if (exmemRegWrite__i && (exmemRd__i != '0) && (exmemRd__i == r_rt))
      w_fwd_b = exmemResult__i;
    else if (memwbRegWrite__i && (memwbRd__i != '0) && (memwbRd__i == r_rt))
      w_fwd_b = memwbData__i;
  end

  assign dataA__o     = w_fwd_a;
  assign dataB__o     = r_alu_src ? r_imm : w_fwd_b;
  assign storeData__o = w_fwd_b;
  assign ALUCtrl__o   = r_alu_ctrl;
  assign writeReg__o  = r_write_reg;

  assign valid__o    = r_valid;
  assign RegWrite__o = r_valid & r_reg_write;
  assign MemRead__o  = r_valid & r_mem_read;
  assign MemWrite__o = r_valid & r_mem_write;
  assign MemToReg__o = r_valid & r_mem_to_reg;
  assign Branch__o   = r_valid & r_branch;

  // Deliberately ignores stall: the hazard unit must see the request while it holds IF/ID.
  assign loadUseHazard__o = r_valid & r_mem_read & (r_write_reg != '0) & valid__i &
                            ((r_write_reg == rs__i) | (r_write_reg == rt__i));

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
// ============================================================================
// Module      : tb_id_ex_pipe
// Description : Scoreboard testbench for the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rstn, stall, flush, valid_i;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  rs, rt, rd;
  logic [2:0]  alu_ctrl;
  logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch;
  logic        exmem_rw, memwb_rw;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_res, memwb_data;

  logic [31:0] o_a, o_b, o_st;
  logic [2:0]  o_op;
  logic [4:0]  o_wr;
  logic        o_v, o_rw, o_mr, o_mw, o_m2r, o_br, o_hz;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] a, b, st;
    logic [2:0]  op;
    logic [4:0]  wr;
    logic        v, rw, mr, mw, m2r, br;
  } exp_t;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [2:0]  op;
    logic        asrc, rdst, rw, mr, mw, m2r, br;
  } instr_t;

  exp_t sb[$];
  logic hz_q[$];
  exp_t obs, e;
  logic he;

  always #5 clk = ~clk;

  id_ex_pipe #(.DW(32), .RW(5)) dut (
    .clk__i(clk), .rstn__i(rstn), .stall__i(stall), .flush__i(flush), .valid__i(valid_i),
    .rsData__i(rs_data), .rtData__i(rt_data), .imm__i(imm),
    .rs__i(rs), .rt__i(rt), .rd__i(rd), .ALUCtrl__i(alu_ctrl),
    .ALUSrc__i(alu_src), .RegDst__i(reg_dst), .RegWrite__i(reg_write),
    .MemRead__i(mem_read), .MemWrite__i(mem_write), .MemToReg__i(mem_to_reg), .Branch__i(branch),
    .exmemRegWrite__i(exmem_rw), .exmemRd__i(exmem_rd), .exmemResult__i(exmem_res),
    .memwbRegWrite__i(memwb_rw), .memwbRd__i(memwb_rd), .memwbData__i(memwb_data),
    .dataA__o(o_a), .dataB__o(o_b), .ALUCtrl__o(o_op), .storeData__o(o_st),
    .writeReg__o(o_wr), .valid__o(o_v), .RegWrite__o(o_rw), .MemRead__o(o_mr),
    .MemWrite__o(o_mw), .MemToReg__o(o_m2r), .Branch__o(o_br), .loadUseHazard__o(o_hz)
  );

  function automatic exp_t observe();
    return {o_a, o_b, o_st, o_op, o_wr, o_v, o_rw, o_mr, o_mw, o_m2r, o_br};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, b, st, input logic [2:0] op,
                              input logic [4:0] wr, input logic v, rw, mr, mw, m2r, br);
    return {a, b, st, op, wr, v, rw, mr, mw, m2r, br};
  endfunction

  function automatic instr_t mk_instr(input logic v, input logic [4:0] rs_, rt_, rd_,
                                      input logic [31:0] rsd, rtd, im, input logic [2:0] op,
                                      input logic asrc, rdst, rw, mr, mw, m2r, br);
    return {v, rs_, rt_, rd_, rsd, rtd, im, op, asrc, rdst, rw, mr, mw, m2r, br};
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
    if (exmem_rw && exmem_rd != 5'd0 && exmem_rd == r) return exmem_res;
    if (memwb_rw && memwb_rd != 5'd0 && memwb_rd == r) return memwb_data;
    return d;
  endfunction

  function automatic exp_t exp_for(input instr_t p);
    logic [31:0] fa, fb;
    fa = fwd(p.rs, p.rsd);
    fb = fwd(p.rt, p.rtd);
    return mk(fa, p.asrc ? p.imm : fb, fb, p.op, p.rdst ? p.rd : p.rt,
              p.v, p.v & p.rw, p.v & p.mr, p.v & p.mw, p.v & p.m2r, p.v & p.br);
  endfunction

  task automatic drive(input instr_t p);
    valid_i = p.v; rs = p.rs; rt = p.rt; rd = p.rd;
    rs_data = p.rsd; rt_data = p.rtd; imm = p.imm; alu_ctrl = p.op;
    alu_src = p.asrc; reg_dst = p.rdst; reg_write = p.rw; mem_read = p.mr;
    mem_write = p.mw; mem_to_reg = p.m2r; branch = p.br;
  endtask

  task automatic fwd_set(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mrw, input logic [4:0] mrd, input logic [31:0] mdat);
    exmem_rw = erw; exmem_rd = erd; exmem_res = eres;
    memwb_rw = mrw; memwb_rd = mrd; memwb_data = mdat;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    stall = 1'($urandom); flush = 1'($urandom);
    drive(instr_t'({$urandom, $urandom, $urandom, $urandom}));
    fwd_set(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
    repeat (2) @(negedge clk);
    sb.push_back('0); hz_q.push_back(1'b0);
    #1;
    obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, e); end
    he = hz_q.pop_front(); n_checks++;
    if (o_hz !== he) begin n_fail++; $display("FAIL reset_hazard: got %b expected %b", o_hz, he); end
    @(negedge clk);
    rstn = 1'b1; stall = 1'b0; flush = 1'b0;
    fwd_set(0, 0, 0, 0, 0, 0);
    drive(mk_instr(1, 5'd1, 5'd2, 5'd9, 32'd5, 32'd7, 32'h0, 3'b010, 0, 1, 1, 0, 0, 0, 0));
    sb.push_back(mk(32'd5, 32'd7, 32'd7, 3'b010, 5'd9, 1, 1, 0, 0, 0, 0));
    @(posedge clk); @(negedge clk);
    obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL first_add: got %h expected %h", obs, e); end
  endtask

  task automatic test_forward();
    drive(mk_instr(1, 5'd3, 5'd5, 5'd0, 32'h33, 32'h55, 32'h0, 3'b110, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk); @(negedge clk);
    stall = 1'b1;
    fwd_set(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    sb.push_back(mk(32'h11, 32'h55, 32'h55, 3'b110, 5'd5, 1, 1, 0, 0, 0, 0));
    #1; obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL fwd_exmem_wins: got %h expected %h", obs, e); end
    exmem_rw = 1'b0;
    sb.push_back(mk(32'h22, 32'h55, 32'h55, 3'b110, 5'd5, 1, 1, 0, 0, 0, 0));
    #1; obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL fwd_memwb: got %h expected %h", obs, e); end
    fwd_set(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    sb.push_back(mk(32'h33, 32'h55, 32'h55, 3'b110, 5'd5, 1, 1, 0, 0, 0, 0));
    #1; obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL fwd_reg0: got %h expected %h", obs, e); end
    fwd_set(0, 5'd5, 32'h11, 1, 5'd5, 32'h66);
    sb.push_back(mk(32'h33, 32'h66, 32'h66, 3'b110, 5'd5, 1, 1, 0, 0, 0, 0));
    #1; obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL fwd_b_memwb: got %h expected %h", obs, e); end
    @(negedge clk);
    stall = 1'b0;
    fwd_set(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_imm_store();
    drive(mk_instr(1, 5'd6, 5'd4, 5'd0, 32'h60, 32'h44, 32'hFFFF_FFFC, 3'b010, 1, 0, 0, 0, 1, 0, 0));
    sb.push_back(mk(32'h60, 32'hFFFF_FFFC, 32'hABCD, 3'b010, 5'd4, 1, 0, 0, 1, 0, 0));
    @(posedge clk); @(negedge clk);
    fwd_set(1, 5'd4, 32'hABCD, 0, 0, 0);
    #1; obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL sw_imm_store: got %h expected %h", obs, e); end
    fwd_set(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall_flush();
    exp_t held;
    @(negedge clk);
    drive(mk_instr(1, 5'd10, 5'd11, 5'd12, 32'd100, 32'd200, 32'h0, 3'b110, 0, 1, 1, 0, 0, 0, 1));
    held = mk(32'd100, 32'd200, 32'd200, 3'b110, 5'd12, 1, 1, 0, 0, 0, 1);
    sb.push_back(held);
    @(posedge clk); @(negedge clk);
    obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL pre_stall: got %h expected %h", obs, e); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(mk_instr(1, 5'(i + 20), 5'(i + 21), 5'(i + 22), 32'(i), 32'(i + 1), 32'h9,
                     3'b001, 1, 0, 0, 1, 1, 1, 0));
      sb.push_back(held);
      @(posedge clk); @(negedge clk);
      obs = observe(); e = sb.pop_front(); n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, e); end
    end
    flush = 1'b1;
    sb.push_back('0);
    @(posedge clk); @(negedge clk);
    obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL flush_over_stall: got %h expected %h", obs, e); end
    stall = 1'b0; flush = 1'b0;
    drive(mk_instr(1, 5'd13, 5'd14, 5'd15, 32'h130, 32'h140, 32'h0, 3'b011, 0, 1, 1, 0, 0, 0, 0));
    sb.push_back(mk(32'h130, 32'h140, 32'h140, 3'b011, 5'd15, 1, 1, 0, 0, 0, 0));
    @(posedge clk); @(negedge clk);
    obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL capture_after_flush: got %h expected %h", obs, e); end
  endtask

  task automatic test_load_use();
    drive(mk_instr(1, 5'd1, 5'd8, 5'd0, 32'h10, 32'h80, 32'h4, 3'b010, 1, 0, 1, 1, 0, 1, 0));
    sb.push_back(mk(32'h10, 32'h4, 32'h80, 3'b010, 5'd8, 1, 1, 1, 0, 1, 0));
    @(posedge clk); @(negedge clk);
    obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL lw_capture: got %h expected %h", obs, e); end
    stall = 1'b1;
    drive(mk_instr(1, 5'd8, 5'd3, 5'd4, 0, 0, 0, 3'b010, 0, 1, 1, 0, 0, 0, 0));
    hz_q.push_back(1'b1);
    #1; he = hz_q.pop_front(); n_checks++;
    if (o_hz !== he) begin n_fail++; $display("FAIL hazard_rs: got %b expected %b", o_hz, he); end
    rs = 5'd9; rt = 5'd8;
    hz_q.push_back(1'b1);
    #1; he = hz_q.pop_front(); n_checks++;
    if (o_hz !== he) begin n_fail++; $display("FAIL hazard_rt: got %b expected %b", o_hz, he); end
    valid_i = 1'b0;
    hz_q.push_back(1'b0);
    #1; he = hz_q.pop_front(); n_checks++;
    if (o_hz !== he) begin n_fail++; $display("FAIL hazard_id_invalid: got %b expected %b", o_hz, he); end
    valid_i = 1'b1; rs = 5'd2; rt = 5'd3;
    hz_q.push_back(1'b0);
    #1; he = hz_q.pop_front(); n_checks++;
    if (o_hz !== he) begin n_fail++; $display("FAIL hazard_no_match: got %b expected %b", o_hz, he); end
    @(negedge clk);
    stall = 1'b0;
    drive(mk_instr(1, 5'd1, 5'd0, 5'd0, 32'h10, 32'h0, 32'h4, 3'b010, 1, 0, 1, 1, 0, 1, 0));
    @(posedge clk); @(negedge clk);
    stall = 1'b1;
    drive(mk_instr(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 3'b010, 0, 1, 1, 0, 0, 0, 0));
    hz_q.push_back(1'b0);
    #1; he = hz_q.pop_front(); n_checks++;
    if (o_hz !== he) begin n_fail++; $display("FAIL hazard_reg0: got %b expected %b", o_hz, he); end
    @(negedge clk);
    stall = 1'b0;
    drive(mk_instr(0, 5'd1, 5'd8, 5'd0, 32'h10, 32'h80, 32'h4, 3'b010, 1, 0, 1, 1, 0, 1, 1));
    sb.push_back(mk(32'h10, 32'h4, 32'h80, 3'b010, 5'd8, 0, 0, 0, 0, 0, 0));
    @(posedge clk); @(negedge clk);
    stall = 1'b1;
    obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL invalid_is_bubble: got %h expected %h", obs, e); end
    drive(mk_instr(1, 5'd8, 5'd8, 5'd0, 0, 0, 0, 3'b010, 0, 1, 1, 0, 0, 0, 0));
    hz_q.push_back(1'b0);
    #1; he = hz_q.pop_front(); n_checks++;
    if (o_hz !== he) begin n_fail++; $display("FAIL hazard_ex_invalid: got %b expected %b", o_hz, he); end
    @(negedge clk);
    stall = 1'b0;
  endtask

  task automatic test_async_reset();
    drive(mk_instr(1, 5'd7, 5'd6, 5'd5, 32'h70, 32'h60, 32'h0, 3'b000, 0, 1, 1, 0, 0, 0, 0));
    @(posedge clk);
    #2;
    stall = 1'b1;
    rstn = 1'b0;
    sb.push_back('0);
    #1; obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL async_reset_clear: got %h expected %h", obs, e); end
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); @(negedge clk);
    sb.push_back('0);
    obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_held_over_edge: got %h expected %h", obs, e); end
    rstn = 1'b1;
    drive(mk_instr(1, 5'd7, 5'd6, 5'd5, 32'h70, 32'h60, 32'h0, 3'b100, 0, 1, 1, 0, 0, 0, 0));
    sb.push_back(mk(32'h70, 32'h60, 32'h60, 3'b100, 5'd5, 1, 1, 0, 0, 0, 0));
    @(posedge clk); @(negedge clk);
    obs = observe(); e = sb.pop_front(); n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL capture_after_reset: got %h expected %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    instr_t prev, cur;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      fwd_set(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      cur = instr_t'({$urandom, $urandom, $urandom, $urandom});
      cur.rs = 5'($urandom_range(0, 7));
      cur.rt = 5'($urandom_range(0, 7));
      cur.rd = 5'($urandom_range(0, 7));
      drive(cur);
      if (i > 0) begin
        sb.push_back(exp_for(prev));
        hz_q.push_back(prev.v & prev.mr & cur.v &
                       ((prev.rdst ? prev.rd : prev.rt) != 5'd0) &
                       (((prev.rdst ? prev.rd : prev.rt) == cur.rs) |
                        ((prev.rdst ? prev.rd : prev.rt) == cur.rt)));
        #1;
        obs = observe(); e = sb.pop_front(); n_checks++;
        if (obs !== e) begin n_fail++; $display("FAIL b2b_outputs[%0d]: got %h expected %h", i, obs, e); end
        he = hz_q.pop_front(); n_checks++;
        if (o_hz !== he) begin n_fail++; $display("FAIL b2b_hazard[%0d]: got %b expected %b", i, o_hz, he); end
      end
      prev = cur;
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_imm_store();
    test_stall_flush();
    test_load_use();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
ID/EX pipeline register of the 5-stage MIPS core. It sits directly upstream of the ALU.
- Captures decoded operands and control from ID each cycle.
- Resolves EX/MEM and MEM/WB operand forwarding and the ALUSrc immediate select.
- Drives the ALU operand and control inputs, plus the control and data forwarded on to EX/MEM.
- Flags load-use hazards back to the hazard unit.

Parameters:
DW, 32, datapath width
RW, 5, register-number width

Ports:
clk__i  in  1  core clock, rising edge
rstn__i  in  1  asynchronous active-low reset
stall__i  in  1  hold all registered state
flush__i  in  1  load bubble on next edge
valid__i  in  1  ID slot holds a real instruction
rsData__i  in  DW  register-file read A
rtData__i  in  DW  register-file read B
imm__i  in  DW  sign-extended immediate
rs__i, rt__i, rd__i  in  RW  register numbers from ID
ALUCtrl__i  in  3  ALU op (010 add, 110 sub, 000 and, 001 or, 011 xor, 100 nor, 111 slt)
ALUSrc__i, RegDst__i, RegWrite__i, MemRead__i, MemWrite__i, MemToReg__i, Branch__i  in  1 each  decoded control
exmemRegWrite__i  in  1  EX/MEM writes a register
exmemRd__i  in  RW  EX/MEM destination
exmemResult__i  in  DW  EX/MEM ALU result
memwbRegWrite__i  in  1  MEM/WB writes a register
memwbRd__i  in  RW  MEM/WB destination
memwbData__i  in  DW  MEM/WB write-back data
dataA__o  out  DW  ALU operand A
dataB__o  out  DW  ALU operand B
ALUCtrl__o  out  3  registered ALU op
storeData__o  out  DW  forwarded rt value for SW
writeReg__o  out  RW  destination register
valid__o, RegWrite__o, MemRead__o, MemWrite__o, MemToReg__o, Branch__o  out  1 each  registered control
loadUseHazard__o  out  1  stall request to hazard unit

Behaviour:
- Reset (rstn__i low, asynchronous): all registered state is 0. This gives valid__o=0, all control outputs 0, ALUCtrl__o=000, writeReg__o=0, dataA__o=dataB__o=storeData__o=0.
- Register update on each rising edge, in priority order:
  - flush__i: load a bubble, i.e. every register 0.
  - else stall__i: hold all registers.
  - else: capture all ID inputs.
  - When capturing, the destination is registered as writeReg_q = RegDst__i ? rd__i : rt__i.
- Flush has priority over stall when both are asserted.
- Control outputs are the registered value ANDed with valid_q. A captured instruction with valid__i=0 therefore behaves as a bubble.
- Forwarding is combinational from the registered state and the forwarding inputs. For operand A (rs):
  - exmemRegWrite__i && exmemRd__i!=0 && exmemRd__i==rs_q → exmemResult__i
  - else memwbRegWrite__i && memwbRd__i!=0 && memwbRd__i==rs_q → memwbData__i
  - else rsData_q
  - EX/MEM always wins over MEM/WB. Register 0 is never forwarded.
- Operand B (rt) uses the same rule on rt_q, producing fwdB.
- dataA__o = fwdA. dataB__o = ALUSrc_q ? imm_q : fwdB. storeData__o = fwdB (always forwarded, independent of ALUSrc).
- Latency: ID inputs reach the ALU-facing outputs 1 cycle after capture. Forwarding adds 0 cycles.
- loadUseHazard__o = valid_q & MemRead_q & (writeReg_q!=0) & valid__i & (writeReg_q==rs__i | writeReg_q==rt__i). This output is combinational and is not gated by stall__i.
- The hazard unit responds to loadUseHazard__o by stalling IF/ID and asserting flush__i here for exactly one cycle. On the following edge this block captures normally.
- Reset asserted mid-stall or mid-flush clears state immediately. The first capture happens on the first edge after reset deasserts.

Test Plan:
- Reset: hold rstn__i low with random inputs → all outputs 0. Release, present ADD with rs=1 (data 5) and rt=2 (data 7) → next cycle dataA__o=5, dataB__o=7, ALUCtrl__o=010, RegWrite__o=1, writeReg__o=rd.
- Forward priority: rs_q=3, exmemRd=3 (result 0x11), memwbRd=3 (data 0x22), both RegWrite=1 → dataA__o=0x11. Drop exmemRegWrite → 0x22. Set both Rd=0 → rsData_q.
- Immediate/store: SW with ALUSrc=1, imm=0xFFFFFFFC, rt_q=4, exmemRd=4 (result 0xABCD) → dataB__o=0xFFFFFFFC, storeData__o=0xABCD, MemWrite__o=1.
- Stall/flush: stall__i=1 for 3 cycles while ID inputs change → outputs frozen. Then stall and flush together → bubble: valid__o=0, RegWrite__o=0, MemWrite__o=0.
- Load-use: LW with rt=8 registered, ID presents rs=8, valid__i=1 → loadUseHazard__o=1. Same case with writeReg_q=0, or with valid__i=0 → 0.
- Async reset mid-operation: assert rstn__i low between clock edges while valid__o=1 → outputs clear to 0 without waiting for a clock edge.
